// File: rtl/useq_ctrl.sv
// Microcoded control sequencer: writable microword store, micro-call stack,
// NMI/IRQ entry at instruction retire, and memory-wait stall.
module useq_ctrl #(
  parameter int unsigned STATE_W     = 8,
  parameter int unsigned CTRL_W      = 37,
  parameter int unsigned FLAG_W      = 8,
  parameter int unsigned STACK_D     = 2,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned FETCH_STATE = 1,
  parameter int unsigned IRQ_STATE   = 62,
  parameter int unsigned NMI_STATE   = 63
) (
  input  logic                        ph1,
  input  logic                        reset,
  input  logic                        ready,
  input  logic [7:0]                  data_in,
  input  logic [FLAG_W-1:0]           p,
  input  logic                        irq,
  input  logic                        i_mask,
  input  logic                        nmi,
  input  logic [STATE_W-1:0]          dispatch_state,
  input  logic [FLAG_W-1:0]           branch_mask,
  input  logic                        branch_pol,
  input  logic                        ucode_we,
  input  logic [STATE_W-1:0]          ucode_waddr,
  input  logic [CTRL_W+STATE_W+2:0]   ucode_wdata,
  output logic [7:0]                  opcode_q,
  output logic [CTRL_W-1:0]           controls,
  output logic [STATE_W-1:0]          state,
  output logic                        first_cycle,
  output logic                        stack_err
);

  localparam int unsigned UW   = CTRL_W + STATE_W + 3;
  localparam int unsigned SP_W = $clog2(STACK_D + 1);

  typedef enum logic [1:0] {
    NS_JUMP     = 2'd0,
    NS_DISPATCH = 2'd1,
    NS_BRANCH   = 2'd2,
    NS_CALLRET  = 2'd3
  } nsel_t;

  logic [UW-1:0]      store [2**STATE_W];
  logic [UW-1:0]      uword;
  logic               last;
  nsel_t              nsel;
  logic [STATE_W-1:0] next_addr;
  logic [STATE_W-1:0] state_inc;
  logic [STATE_W-1:0] stack [STACK_D];
  logic [STATE_W-1:0] stack_top;
  logic [SP_W-1:0]    sp;
  logic               taken;
  logic               nmi_q;
  logic               nmi_pend;
  logic               nmi_edge;

  always_ff @(posedge ph1) begin
    if (ucode_we) store[ucode_waddr] <= ucode_wdata;
  end

  assign uword     = store[state];
  assign controls  = uword[UW-1 -: CTRL_W];
  assign last      = uword[STATE_W+2];
  assign nsel      = nsel_t'(uword[STATE_W+1 -: 2]);
  assign next_addr = uword[STATE_W-1:0];
  assign state_inc = state + STATE_W'(1);
  assign taken     = branch_pol ^ (|(branch_mask & p));
  assign nmi_edge  = nmi & ~nmi_q;

  // sp counts entries; the top of stack lives at index sp-1.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_D; i++) begin
      if (sp == SP_W'(i + 1)) stack_top = stack[i];
    end
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      state       <= STATE_W'(RESET_STATE);
      opcode_q    <= '0;
      first_cycle <= 1'b0;
      sp          <= '0;
      nmi_pend    <= 1'b0;
      nmi_q       <= 1'b0;
      stack_err   <= 1'b0;
    end else begin
      nmi_q <= nmi;
      if (ready) begin
        first_cycle <= 1'b0;
        if (last) begin
          sp <= '0;
          if (nmi_pend) begin
            state    <= STATE_W'(NMI_STATE);
            nmi_pend <= 1'b0;
          end else if (irq && !i_mask) begin
            state <= STATE_W'(IRQ_STATE);
          end else begin
            state       <= STATE_W'(FETCH_STATE);
            opcode_q    <= data_in;
            first_cycle <= 1'b1;
          end
        end else begin
          unique case (nsel)
            NS_JUMP:     state <= next_addr;
            NS_DISPATCH: state <= dispatch_state;
            NS_BRANCH:   state <= taken ? next_addr : state_inc;
            NS_CALLRET: begin
              if (next_addr != '1) begin
                if (sp == SP_W'(STACK_D)) begin
                  stack_err <= 1'b1;
                end else begin
                  for (int unsigned i = 0; i < STACK_D; i++) begin
                    if (sp == SP_W'(i)) stack[i] <= state_inc;
                  end
                  sp <= sp + SP_W'(1);
                end
                state <= next_addr;
              end else if (sp == '0) begin
                state     <= STATE_W'(FETCH_STATE);
                stack_err <= 1'b1;
              end else begin
                state <= stack_top;
                sp    <= sp - SP_W'(1);
              end
            end
          endcase
        end
      end
      // Placed last so a fresh edge overrides a same-cycle clear at NMI entry.
      if (nmi_edge) nmi_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_useq_ctrl.sv
// Bench for useq_ctrl: directed walk through sequencing, stall, stack and
// interrupt behaviour, then randomized traffic against a queue-based model.
module tb_useq_ctrl;
  localparam int unsigned SW = 8, CW = 37, FW = 8, SD = 2, UW = CW + SW + 3;
  localparam int unsigned RST_S = 0, FET_S = 1, IRQ_S = 62, NMI_S = 63;

  logic          ph1 = 1'b0;
  logic          reset, ready, irq, i_mask, nmi, branch_pol, ucode_we;
  logic [7:0]    data_in, opcode_q;
  logic [FW-1:0] p, branch_mask;
  logic [SW-1:0] dispatch_state, ucode_waddr, state;
  logic [UW-1:0] ucode_wdata;
  logic [CW-1:0] controls;
  logic          first_cycle, stack_err;

  int unsigned n_tests, n_fail;
  bit          chk_en;

  logic [UW-1:0] m_store [256];
  int unsigned   m_state;
  logic [7:0]    m_op;
  bit            m_first, m_pend, m_nmi_prev, m_err;
  int unsigned   m_stk [$];

  useq_ctrl #(
    .STATE_W(SW), .CTRL_W(CW), .FLAG_W(FW), .STACK_D(SD),
    .RESET_STATE(RST_S), .FETCH_STATE(FET_S), .IRQ_STATE(IRQ_S), .NMI_STATE(NMI_S)
  ) dut (
    .ph1(ph1), .reset(reset), .ready(ready), .data_in(data_in), .p(p),
    .irq(irq), .i_mask(i_mask), .nmi(nmi), .dispatch_state(dispatch_state),
    .branch_mask(branch_mask), .branch_pol(branch_pol), .ucode_we(ucode_we),
    .ucode_waddr(ucode_waddr), .ucode_wdata(ucode_wdata), .opcode_q(opcode_q),
    .controls(controls), .state(state), .first_cycle(first_cycle),
    .stack_err(stack_err)
  );

  always #5 ph1 = ~ph1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] cv(input int unsigned a);
    return CW'(64'(a) * 64'h9E37_79B9 + 64'h15);
  endfunction

  function automatic logic [UW-1:0] mw(input logic [CW-1:0] c, input bit lst,
                                       input logic [1:0] ns, input logic [SW-1:0] nx);
    return {c, lst, ns, nx};
  endfunction

  function automatic logic [UW-1:0] rand_word();
    logic [1:0]    ns;
    logic [SW-1:0] nx;
    ns = 2'($urandom_range(0, 3));
    nx = SW'($urandom);
    if (ns == 2'd3 && $urandom_range(0, 3) == 0) nx = '1;
    return mw(CW'({$urandom(), $urandom()}), ($urandom_range(0, 7) == 0), ns, nx);
  endfunction

  task automatic put(input int unsigned a, input logic [UW-1:0] w);
    ucode_we    = 1'b1;
    ucode_waddr = SW'(a);
    ucode_wdata = w;
  endtask

  // Advance the reference model by one edge, clock the DUT, compare.
  task automatic step();
    logic [UW-1:0] w;
    bit            nedge;
    int unsigned   nx;
    w     = m_store[m_state];
    nedge = nmi && !m_nmi_prev;
    nx    = int'(w[SW-1:0]);
    if (reset) begin
      m_state = RST_S; m_op = 8'h00; m_first = 0; m_pend = 0;
      m_nmi_prev = 0; m_err = 0; m_stk.delete();
    end else begin
      if (ready) begin
        m_first = 0;
        if (w[SW+2]) begin
          m_stk.delete();
          if (m_pend) begin
            m_state = NMI_S; m_pend = 0;
          end else if (irq && !i_mask) begin
            m_state = IRQ_S;
          end else begin
            m_state = FET_S; m_op = data_in; m_first = 1;
          end
        end else begin
          case (int'(w[SW+1:SW]))
            0: m_state = nx;
            1: m_state = int'(dispatch_state);
            2: m_state = ((((branch_mask & p) != 0) ? 1 : 0) ^ int'(branch_pol)) != 0
                         ? nx : (m_state + 1) % 256;
            default: begin
              if (nx != 255) begin
                if (m_stk.size() < SD) m_stk.push_back((m_state + 1) % 256);
                else m_err = 1;
                m_state = nx;
              end else if (m_stk.size() == 0) begin
                m_state = FET_S; m_err = 1;
              end else begin
                m_state = m_stk.pop_back();
              end
            end
          endcase
        end
      end
      if (nedge) m_pend = 1;
      m_nmi_prev = nmi;
    end
    if (ucode_we) m_store[ucode_waddr] = ucode_wdata;
    @(posedge ph1);
    #1;
    ucode_we = 1'b0;
    if (chk_en) begin
      check("state", state, m_state);
      check("opcode_q", opcode_q, m_op);
      check("first_cycle", first_cycle, m_first);
      check("stack_err", stack_err, m_err);
      check("controls", controls, m_store[m_state][UW-1:SW+3]);
    end
  endtask

  task automatic load(input int unsigned a, input bit lst, input int unsigned ns, input int unsigned nx);
    put(a, mw(cv(a), lst, 2'(ns), SW'(nx)));
    step();
  endtask

  initial begin
    reset = 1; ready = 1; irq = 0; i_mask = 0; nmi = 0; branch_pol = 0;
    ucode_we = 0; data_in = 0; p = 0; branch_mask = 0; dispatch_state = 0;
    ucode_waddr = 0; ucode_wdata = 0; n_tests = 0; n_fail = 0; chk_en = 0;
    m_state = 0;

    for (int i = 0; i < 256; i++) begin
      put(i, mw(cv(i), 1, 2'd0, 8'd0));
      step();
    end
    chk_en = 1;
    load(0, 0, 0, 1);   load(1, 0, 0, 2);   load(2, 0, 0, 3);   load(3, 1, 0, 0);
    load(5, 0, 0, 10);  load(10, 0, 2, 20); load(11, 0, 0, 10); load(20, 0, 0, 10);
    load(4, 0, 3, 30);  load(30, 0, 3, 40); load(40, 0, 3, 255); load(31, 0, 3, 255);
    load(50, 0, 3, 52); load(52, 0, 3, 54); load(54, 0, 3, 255); load(51, 0, 3, 255);
    load(6, 0, 3, 255); load(60, 0, 0, 61); load(61, 1, 0, 0);
    load(63, 0, 0, 61); load(62, 0, 0, 61);
    check("rst_state", state, RST_S);
    check("rst_opcode", opcode_q, 0);
    check("rst_first", first_cycle, 0);
    check("rst_err", stack_err, 0);

    // Straight-line program and retire.
    reset = 0; data_in = 8'h69;
    step(); check("seq_1", state, 1);
    step(); check("seq_2", state, 2);
    step(); check("seq_3", state, 3);
    put(1, mw(cv(1), 0, 2'd1, 8'd0)); dispatch_state = 5;
    step(); check("retire_state", state, FET_S);
    check("retire_op", opcode_q, 8'h69); check("retire_first", first_cycle, 1);
    data_in = 8'h00;
    step(); check("dispatch", state, 5); check("first_drop", first_cycle, 0);

    // Memory wait.
    ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); check("stall_state", state, 5); check("stall_op", opcode_q, 8'h69);
      check("stall_ctrl", controls, cv(5));
    end
    ready = 1;
    step(); check("resume", state, 10);

    // Conditional branch, both polarities.
    branch_mask = 8'h02;
    branch_pol = 0; p = 8'h02; step(); check("br_p0_t", state, 20); step();
    p = 8'h00; step(); check("br_p0_n", state, 11); step();
    branch_pol = 1; p = 8'h02; step(); check("br_p1_t", state, 11); step();
    p = 8'h00; step(); check("br_p1_n", state, 20); step();
    p = 8'h02; put(11, mw(cv(11), 0, 2'd0, 8'd4)); step(); step();
    check("to_call", state, 4);

    // Micro-subroutines, overflow and underflow.
    step(); check("call_30", state, 30);
    step(); check("call_40", state, 40);
    step(); check("ret_31", state, 31);
    put(5, mw(cv(5), 0, 2'd3, 8'd50));
    step(); check("ret_5", state, 5); check("no_err", stack_err, 0);
    step(); step(); check("nest2", state, 52);
    step(); check("ovf_jump", state, 54); check("ovf_err", stack_err, 1);
    step(); check("pop_51", state, 51);
    step(); check("pop_6", state, 6);
    dispatch_state = 60;
    step(); check("unf_state", state, FET_S); check("unf_err", stack_err, 1);
    check("unf_first", first_cycle, 0);

    // Interrupt entry at retire.
    irq = 1; i_mask = 0;
    step(); check("int_60", state, 60);
    nmi = 1; step(); nmi = 0;
    step(); check("nmi_entry", state, NMI_S);
    step(); step(); check("irq_entry", state, IRQ_S);
    step(); i_mask = 1; data_in = 8'hA5;
    step(); check("masked", state, FET_S); check("masked_op", opcode_q, 8'hA5);

    // NMI edge coinciding with the cycle that consumes the pending NMI.
    nmi = 1; step(); check("nmi2_60", state, 60);
    nmi = 0; step();
    nmi = 1; step(); check("nmi2_entry", state, NMI_S);
    nmi = 0; step();
    step(); check("nmi_rearm", state, NMI_S);
    irq = 0; step(); step(); check("back_fetch", state, FET_S);

    // Reset during a stall with a call pending.
    dispatch_state = 4; step(); check("pre_call", state, 4);
    ready = 0; step(); step();
    reset = 1; step();
    check("rst2_state", state, RST_S); check("rst2_err", stack_err, 0);
    check("rst2_first", first_cycle, 0); check("rst2_op", opcode_q, 0);

    // Randomized traffic.
    ready = 1;
    for (int i = 0; i < 256; i++) begin
      put(i, rand_word());
      step();
    end
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      reset          = ($urandom_range(0, 299) == 0);
      ready          = ($urandom_range(0, 9) != 0);
      irq            = ($urandom_range(0, 3) == 0);
      i_mask         = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 5) == 0) nmi = ~nmi;
      p              = FW'($urandom);
      branch_mask    = FW'($urandom);
      branch_pol     = 1'($urandom);
      dispatch_state = SW'($urandom);
      data_in        = 8'($urandom);
      if ($urandom_range(0, 15) == 0) put($urandom_range(0, 255), rand_word());
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
